// File: rtl/pdu_run_ctrl_if.sv
// rtl/pdu_run_ctrl_if.sv - run-controller <-> pipeline control unit link
interface pdu_run_ctrl_if;
  logic        pdu_run;
  logic [31:0] pdu_breakpoint;
  logic        cpu_stop;
  logic [31:0] id_pc;

  modport master (
    output pdu_run,
    output pdu_breakpoint,
    input  cpu_stop,
    input  id_pc
  );

  modport slave (
    input  pdu_run,
    input  pdu_breakpoint,
    output cpu_stop,
    output id_pc
  );
endinterface

// File: rtl/pdu_run_ctrl.sv
// rtl/pdu_run_ctrl.sv - debug run controller: button debounce, breakpoint entry, launch FSM
// Optional halt counter output is enabled by defining PDU_HALT_CNT_EN.
module pdu_run_ctrl #(
  parameter int          DB_CYCLES  = 16,
  parameter int          LAUNCH_TMO = 64,
  parameter logic [31:0] BP_OFF     = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_btn_run,
  input  logic                  i_btn_lo,
  input  logic                  i_btn_hi,
  input  logic                  i_btn_clr,
  input  logic [15:0]           i_sw,
  pdu_run_ctrl_if.master        pcu,
  output logic [31:0]           o_bp_reg,
  output logic                  o_bp_valid,
  output logic [1:0]            o_run_state,
  output logic                  o_launch_err
`ifdef PDU_HALT_CNT_EN
  ,output logic [15:0]          o_halt_cnt
`endif
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(LAUNCH_TMO + 1);
  localparam int B_RUN = 0;
  localparam int B_LO  = 1;
  localparam int B_HI  = 2;
  localparam int B_CLR = 3;

  typedef enum logic [1:0] {
    S_STOP    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_CONFIRM = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  logic [3:0]    w_btn_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_lvl;
  logic [3:0]    r_lvl_d;
  logic [CW-1:0] r_db_cnt [4];
  logic [3:0]    w_evt;

  state_t        r_state;
  logic          r_pdu_run;
  logic [31:0]   r_pdu_bp;
  logic [31:0]   r_bp;
  logic          r_bp_valid;
  logic [31:0]   r_halt_pc;
  logic [TW-1:0] r_tmo;
  logic          r_launch_err;
  logic          r_stop_d;
  logic          r_mask;
  logic          w_mask_nxt;
  logic          w_tmo_done;
  logic          w_stop_rise;
  logic [15:0]   r_halt_cnt;

  assign w_btn_raw   = {i_btn_clr, i_btn_hi, i_btn_lo, i_btn_run};
  assign w_evt       = r_lvl & ~r_lvl_d;
  assign w_tmo_done  = (r_tmo == TW'(LAUNCH_TMO - 1));
  assign w_stop_rise = pcu.cpu_stop & ~r_stop_d;

  // Accepted level flips only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          r_lvl[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Next mask value feeds pdu_breakpoint directly so the unmask is seen one clk after id_pc moves.
  always_comb begin
    w_mask_nxt = r_mask;
    case (r_state)
      S_STOP: begin
        if (!pcu.cpu_stop)    w_mask_nxt = 1'b0;
        else if (w_evt[B_RUN]) w_mask_nxt = 1'b1;
      end
      S_CONFIRM: begin
        if (pcu.cpu_stop && w_tmo_done) w_mask_nxt = 1'b0;
      end
      S_RUN: begin
        if (w_stop_rise || (pcu.id_pc != r_halt_pc)) w_mask_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_STOP;
      r_pdu_run    <= 1'b0;
      r_pdu_bp     <= BP_OFF;
      r_bp         <= '0;
      r_bp_valid   <= 1'b0;
      r_halt_pc    <= '0;
      r_tmo        <= '0;
      r_launch_err <= 1'b0;
      r_stop_d     <= 1'b0;
      r_mask       <= 1'b0;
      r_halt_cnt   <= '0;
    end else begin
      r_stop_d  <= pcu.cpu_stop;
      r_mask    <= w_mask_nxt;
      r_pdu_run <= 1'b0;
      r_pdu_bp  <= (r_bp_valid && !w_mask_nxt) ? r_bp : BP_OFF;
      case (r_state)
        S_STOP: begin
          if (!pcu.cpu_stop) begin
            r_state <= S_RUN;
          end else if (w_evt[B_RUN]) begin
            r_halt_pc <= pcu.id_pc;
            r_state   <= S_LAUNCH;
            r_pdu_run <= 1'b1;
          end
          // Breakpoint edits are only honoured while halted; priority clr > hi > lo.
          if (w_evt[B_CLR]) begin
            r_bp       <= '0;
            r_bp_valid <= 1'b0;
            r_halt_cnt <= '0;
          end else if (w_evt[B_HI]) begin
            r_bp[31:16] <= i_sw;
            r_bp_valid  <= 1'b1;
          end else if (w_evt[B_LO]) begin
            r_bp[15:0] <= i_sw;
            r_bp_valid <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_state <= S_CONFIRM;
          r_tmo   <= '0;
        end
        S_CONFIRM: begin
          if (!pcu.cpu_stop) begin
            r_state      <= S_RUN;
            r_launch_err <= 1'b0;
          end else if (w_tmo_done) begin
            r_state      <= S_STOP;
            r_launch_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RUN: begin
          if (w_stop_rise) begin
            r_state <= S_STOP;
            if (r_halt_cnt != 16'hFFFF) r_halt_cnt <= r_halt_cnt + 16'd1;
          end
        end
        default: r_state <= S_STOP;
      endcase
    end
  end

  assign pcu.pdu_run        = r_pdu_run;
  assign pcu.pdu_breakpoint = r_pdu_bp;
  assign o_bp_reg           = r_bp;
  assign o_bp_valid         = r_bp_valid;
  assign o_run_state        = r_state;
  assign o_launch_err       = r_launch_err;

`ifdef PDU_HALT_CNT_EN
  assign o_halt_cnt = r_halt_cnt;
`else
  logic w_halt_cnt_unused;
  assign w_halt_cnt_unused = ^r_halt_cnt;
`endif

endmodule

// File: tb/tb_pdu_run_ctrl.sv
// tb/tb_pdu_run_ctrl.sv - directed self-checking bench for pdu_run_ctrl
module tb_pdu_run_ctrl;
  localparam logic [31:0] BP_OFF = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn;
  logic        btn_run, btn_lo, btn_hi, btn_clr;
  logic [15:0] sw;
  logic [31:0] bp_reg;
  logic        bp_valid;
  logic [1:0]  run_state;
  logic        launch_err;
`ifdef PDU_HALT_CNT_EN
  logic [15:0] halt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pdu_run_ctrl_if pcu ();

  pdu_run_ctrl #(.DB_CYCLES(4), .LAUNCH_TMO(8), .BP_OFF(BP_OFF)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_btn_run    (btn_run),
    .i_btn_lo     (btn_lo),
    .i_btn_hi     (btn_hi),
    .i_btn_clr    (btn_clr),
    .i_sw         (sw),
    .pcu          (pcu),
    .o_bp_reg     (bp_reg),
    .o_bp_valid   (bp_valid),
    .o_run_state  (run_state),
    .o_launch_err (launch_err)
`ifdef PDU_HALT_CNT_EN
    ,.o_halt_cnt  (halt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    {btn_clr, btn_hi, btn_lo, btn_run} = m;
    tick(hold);
    {btn_clr, btn_hi, btn_lo, btn_run} = 4'b0;
    tick(12);
  endtask

  task automatic launch_and_run();
    btn_run = 1'b1;
    tick(9);
    pcu.cpu_stop = 1'b0;
    tick(1);
    btn_run = 1'b0;
    tick(12);
  endtask

  task automatic stop_cpu();
    pcu.cpu_stop = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    pcu.cpu_stop = 1'b1;
    pcu.id_pc = 32'h40;
    tick(3);
    n_tests++; if (pcu.pdu_run !== 1'b0) begin n_fail++; $display("FAIL reset_pdu_run got %h want 0", pcu.pdu_run); end
    n_tests++; if (pcu.pdu_breakpoint !== BP_OFF) begin n_fail++; $display("FAIL reset_pdu_bp got %h want %h", pcu.pdu_breakpoint, BP_OFF); end
    n_tests++; if (bp_reg !== 32'h0) begin n_fail++; $display("FAIL reset_bp_reg got %h want 0", bp_reg); end
    n_tests++; if (bp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bp_valid got %h want 0", bp_valid); end
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", run_state); end
    n_tests++; if (launch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %h want 0", launch_err); end
    rstn = 1'b1;
    tick(2);
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL reset_idle_state got %0d want 0", run_state); end
  endtask

  task automatic test_bp_entry();
    sw = 16'h0040;
    press(4'b0010, 10);
    n_tests++; if (bp_reg !== 32'h0000_0040) begin n_fail++; $display("FAIL bp_lo got %h want 00000040", bp_reg); end
    n_tests++; if (bp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_lo_valid got %h want 1", bp_valid); end
    sw = 16'h0000;
    press(4'b0100, 10);
    n_tests++; if (bp_reg !== 32'h0000_0040) begin n_fail++; $display("FAIL bp_hi got %h want 00000040", bp_reg); end
    n_tests++; if (pcu.pdu_breakpoint !== 32'h0000_0040) begin n_fail++; $display("FAIL bp_hi_pdu got %h want 00000040", pcu.pdu_breakpoint); end
    sw = 16'hABCD;
    press(4'b0110, 10);
    n_tests++; if (bp_reg !== 32'hABCD_0040) begin n_fail++; $display("FAIL bp_hi_over_lo got %h want abcd0040", bp_reg); end
    sw = 16'h0000;
    press(4'b0100, 10);
    n_tests++; if (bp_reg !== 32'h0000_0040) begin n_fail++; $display("FAIL bp_restore got %h want 00000040", bp_reg); end
  endtask

  task automatic test_debounce();
    int pulses = 0;
    int first = 0;
    for (int k = 0; k < 20; k++) begin
      btn_run = ((k % 4) < 2);
      tick(1);
      if (pcu.pdu_run === 1'b1) pulses++;
    end
    btn_run = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (pcu.pdu_run === 1'b1) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL db_glitch_pulses got %0d want 0", pulses); end
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL db_glitch_state got %0d want 0", run_state); end
    pulses = 0;
    btn_run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (pcu.pdu_run === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 9) pcu.cpu_stop = 1'b0;
      if (k == 10) btn_run = 1'b0;
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL db_clean_pulses got %0d want 1", pulses); end
    n_tests++; if (first !== 7) begin n_fail++; $display("FAIL db_latency got %0d want 7", first); end
    n_tests++; if (run_state !== 2'd3) begin n_fail++; $display("FAIL db_run_state got %0d want 3", run_state); end
    stop_cpu();
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL db_stop_state got %0d want 0", run_state); end
  endtask

  task automatic test_resume_mask();
    int pulses = 0;
    int first = 0;
    pcu.id_pc = 32'h40;
    pcu.cpu_stop = 1'b1;
    btn_run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (pcu.pdu_run === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    btn_run = 1'b0;
    n_tests++; if (pulses !== 1 || first !== 7) begin n_fail++; $display("FAIL rm_pulse got n=%0d at %0d want 1 at 7", pulses, first); end
    n_tests++; if (run_state !== 2'd2) begin n_fail++; $display("FAIL rm_confirm got %0d want 2", run_state); end
    n_tests++; if (pcu.pdu_breakpoint !== BP_OFF) begin n_fail++; $display("FAIL rm_launch_bp got %h want %h", pcu.pdu_breakpoint, BP_OFF); end
    pcu.cpu_stop = 1'b0;
    tick(3);
    n_tests++; if (run_state !== 2'd3) begin n_fail++; $display("FAIL rm_run got %0d want 3", run_state); end
    n_tests++; if (pcu.pdu_breakpoint !== BP_OFF) begin n_fail++; $display("FAIL rm_masked got %h want %h", pcu.pdu_breakpoint, BP_OFF); end
    pcu.id_pc = 32'h44;
    tick(1);
    n_tests++; if (pcu.pdu_breakpoint !== 32'h40) begin n_fail++; $display("FAIL rm_unmask got %h want 00000040", pcu.pdu_breakpoint); end
    pcu.id_pc = 32'h40;
    tick(1);
    n_tests++; if (pcu.pdu_breakpoint !== 32'h40) begin n_fail++; $display("FAIL rm_stays_live got %h want 00000040", pcu.pdu_breakpoint); end
    stop_cpu();
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL rm_stop got %0d want 0", run_state); end
    tick(10);
  endtask

  task automatic test_launch_timeout();
    pcu.cpu_stop = 1'b1;
    btn_run = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k == 7) begin
        n_tests++; if (pcu.pdu_run !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse got %h want 1", pcu.pdu_run); end
      end
      if (k == 10) btn_run = 1'b0;
      if (k == 15) begin
        n_tests++; if (run_state !== 2'd2 || launch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_before got state=%0d err=%h want 2/0", run_state, launch_err); end
      end
    end
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL tmo_state got %0d want 0", run_state); end
    n_tests++; if (launch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %h want 1", launch_err); end
    n_tests++; if (pcu.pdu_breakpoint !== 32'h40) begin n_fail++; $display("FAIL tmo_unmask got %h want 00000040", pcu.pdu_breakpoint); end
    tick(8);
    launch_and_run();
    n_tests++; if (run_state !== 2'd3) begin n_fail++; $display("FAIL tmo_rerun_state got %0d want 3", run_state); end
    n_tests++; if (launch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear got %h want 0", launch_err); end
    stop_cpu();
  endtask

  task automatic test_edit_lockout();
    pcu.id_pc = 32'h40;
    launch_and_run();
    n_tests++; if (run_state !== 2'd3) begin n_fail++; $display("FAIL lock_run got %0d want 3", run_state); end
    n_tests++; if (pcu.pdu_breakpoint !== BP_OFF) begin n_fail++; $display("FAIL lock_masked got %h want %h", pcu.pdu_breakpoint, BP_OFF); end
    press(4'b1000, 10);
    n_tests++; if (bp_reg !== 32'h40 || bp_valid !== 1'b1) begin n_fail++; $display("FAIL lock_clr_ignored got %h/%h want 00000040/1", bp_reg, bp_valid); end
    stop_cpu();
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL lock_stop got %0d want 0", run_state); end
    n_tests++; if (pcu.pdu_breakpoint !== 32'h40) begin n_fail++; $display("FAIL lock_stop_unmask got %h want 00000040", pcu.pdu_breakpoint); end
    sw = 16'h1234;
    press(4'b1100, 10);
    n_tests++; if (bp_reg !== 32'h0 || bp_valid !== 1'b0) begin n_fail++; $display("FAIL prio_clr got %h/%h want 0/0", bp_reg, bp_valid); end
    n_tests++; if (pcu.pdu_breakpoint !== BP_OFF) begin n_fail++; $display("FAIL prio_clr_pdu got %h want %h", pcu.pdu_breakpoint, BP_OFF); end
    sw = 16'h0040;
    press(4'b0010, 10);
  endtask

  task automatic test_reset_mid_launch();
    pcu.cpu_stop = 1'b1;
    btn_run = 1'b1;
    tick(9);
    n_tests++; if (run_state !== 2'd2) begin n_fail++; $display("FAIL rst_pre_state got %0d want 2", run_state); end
    rstn = 1'b0;
    #1;
    n_tests++; if (pcu.pdu_run !== 1'b0) begin n_fail++; $display("FAIL rst_mid_run got %h want 0", pcu.pdu_run); end
    n_tests++; if (run_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got %0d want 0", run_state); end
    n_tests++; if (pcu.pdu_breakpoint !== BP_OFF) begin n_fail++; $display("FAIL rst_mid_bp got %h want %h", pcu.pdu_breakpoint, BP_OFF); end
    n_tests++; if (bp_reg !== 32'h0) begin n_fail++; $display("FAIL rst_mid_bpreg got %h want 0", bp_reg); end
    btn_run = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(12);
  endtask

`ifdef PDU_HALT_CNT_EN
  task automatic test_halt_cnt();
    n_tests++; if (halt_cnt !== 16'd0) begin n_fail++; $display("FAIL hc_reset got %0d want 0", halt_cnt); end
    for (int i = 0; i < 3; i++) begin
      launch_and_run();
      stop_cpu();
      tick(2);
    end
    n_tests++; if (halt_cnt !== 16'd3) begin n_fail++; $display("FAIL hc_three got %0d want 3", halt_cnt); end
    press(4'b1000, 10);
    n_tests++; if (halt_cnt !== 16'd0) begin n_fail++; $display("FAIL hc_clr got %0d want 0", halt_cnt); end
  endtask
`endif

  initial begin
    rstn = 1'b0;
    {btn_clr, btn_hi, btn_lo, btn_run} = 4'b0;
    sw = 16'h0;
    pcu.cpu_stop = 1'b1;
    pcu.id_pc = 32'h40;
    tick(1);
    test_reset();
    test_bp_entry();
    test_debounce();
    test_resume_mask();
    test_launch_timeout();
    test_edit_lockout();
    test_reset_mid_launch();
`ifdef PDU_HALT_CNT_EN
    test_halt_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
